cmp_result_checker: RTL and testbench

Response-side companion to the comparator stimulus driver. It accepts a stream of operand pairs, computes the expected gt/eq/lt for each pair, and checks the comparator's outputs after a fixed latency. It keeps pass/fail counts and captures the first failing pair. It sits beside the comparator DUT in self-checking benches and on-board test harnesses.

---
 rtl/cmp_result_checker.sv | 189 ++++++++++++++++++
 tb/tb_cmp_result_checker.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_result_checker.sv
// Response checker for a magnitude comparator: pipelines operand pairs, compares DUT outputs
// LATENCY cycles later, and keeps pass/fail counts. Define CHK_ONEHOT_EN to add onehot_err_cnt.
module cmp_result_checker #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    input  logic             vec_last,
    input  logic [WIDTH-1:0] vec_a,
    input  logic [WIDTH-1:0] vec_b,
    input  logic             dut_gt,
    input  logic             dut_eq,
    input  logic             dut_lt,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             fail_seen,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b,
    output logic [1:0]       state_dbg
`ifdef CHK_ONEHOT_EN
    ,
    output logic [CNT_W-1:0] onehot_err_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_pass_cnt;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic               r_fail_seen;
    logic [WIDTH-1:0]   r_ff_a;
    logic [WIDTH-1:0]   r_ff_b;

    // Pipeline slots; slot LATENCY-1 is the one compared on the current edge.
    logic               r_pv   [LATENCY];
    logic               r_pl   [LATENCY];
    logic [WIDTH-1:0]   r_pa   [LATENCY];
    logic [WIDTH-1:0]   r_pb   [LATENCY];
    logic [2:0]         r_pexp [LATENCY];

    logic               w_clear;
    logic               w_accept;
    logic               w_cmp;
    logic               w_pass;
    logic               w_onehot;
    logic [2:0]         w_got;
    logic [2:0]         w_exp_in;

    always_comb begin
        w_clear  = start && (r_state == S_IDLE || r_state == S_DONE);
        w_accept = (r_state == S_RUN) && vec_valid;
        w_cmp    = (r_state == S_RUN || r_state == S_DRAIN) && r_pv[LATENCY-1];
        w_got    = {dut_gt, dut_eq, dut_lt};
        w_pass   = (w_got == r_pexp[LATENCY-1]);
        w_onehot = (w_got == 3'b100) || (w_got == 3'b010) || (w_got == 3'b001);
        w_exp_in = {vec_a > vec_b, vec_a == vec_b, vec_a < vec_b};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pv[i]   <= 1'b0;
                r_pl[i]   <= 1'b0;
                r_pa[i]   <= '0;
                r_pb[i]   <= '0;
                r_pexp[i] <= '0;
            end
        end else if (w_clear) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pl[i] <= 1'b0;
            end
        end else begin
            r_pv[0]   <= w_accept;
            r_pl[0]   <= w_accept && vec_last;
            r_pa[0]   <= vec_a;
            r_pb[0]   <= vec_b;
            r_pexp[0] <= w_exp_in;
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i]   <= r_pv[i-1];
                r_pl[i]   <= r_pl[i-1];
                r_pa[i]   <= r_pa[i-1];
                r_pb[i]   <= r_pb[i-1];
                r_pexp[i] <= r_pexp[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_fail_seen <= 1'b0;
            r_ff_a      <= '0;
            r_ff_b      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_accept && vec_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_cmp && r_pl[LATENCY-1]) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // The final comparison is counted on the same edge that enters DONE.
            if (w_clear) begin
                r_pass_cnt  <= '0;
                r_fail_cnt  <= '0;
                r_fail_seen <= 1'b0;
                r_ff_a      <= '0;
                r_ff_b      <= '0;
            end else if (w_cmp) begin
                if (w_pass) begin
                    if (r_pass_cnt != CNT_MAX) r_pass_cnt <= r_pass_cnt + 1'b1;
                end else begin
                    if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + 1'b1;
                    r_fail_seen <= 1'b1;
                    if (!r_fail_seen) begin
                        r_ff_a <= r_pa[LATENCY-1];
                        r_ff_b <= r_pb[LATENCY-1];
                    end
                end
            end
        end
    end

`ifdef CHK_ONEHOT_EN
    logic [CNT_W-1:0] r_onehot_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_onehot_cnt <= '0;
        end else if (w_clear) begin
            r_onehot_cnt <= '0;
        end else if (w_cmp && !w_onehot && r_onehot_cnt != CNT_MAX) begin
            r_onehot_cnt <= r_onehot_cnt + 1'b1;
        end
    end

    assign onehot_err_cnt = r_onehot_cnt;
`else
    logic w_onehot_unused;
    assign w_onehot_unused = w_onehot;
`endif

    assign busy         = r_busy;
    assign done         = r_done;
    assign pass_cnt     = r_pass_cnt;
    assign fail_cnt     = r_fail_cnt;
    assign fail_seen    = r_fail_seen;
    assign first_fail_a = r_ff_a;
    assign first_fail_b = r_ff_b;
    assign state_dbg    = r_state;

endmodule

// File: tb/tb_cmp_result_checker.sv
// Bench for cmp_result_checker: three instances (latency 1, latency 3, 2-bit counters) share
// one vector stream; each sees a behavioural comparator delayed by its own latency.
module tb_cmp_result_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start, vec_valid, vec_last;
  logic [3:0] vec_a, vec_b;
  logic [2:0] flt;      // fault mask xor'ed into the model comparator output
  logic       sb_acc;   // bench expects the current vector to be accepted

  // model comparators
  logic [2:0] d1;
  logic [2:0] d3 [3];
  always @(posedge clk) begin
    d1    <= {vec_a > vec_b, vec_a == vec_b, vec_a < vec_b} ^ flt;
    d3[0] <= {vec_a > vec_b, vec_a == vec_b, vec_a < vec_b} ^ flt;
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end

  logic       o1_busy, o1_done, o1_fs, o3_busy, o3_done, o3_fs, os_busy, os_done, os_fs;
  logic [7:0] o1_pass, o1_fail, o3_pass, o3_fail;
  logic [1:0] os_pass, os_fail;
  logic [3:0] o1_ffa, o1_ffb, o3_ffa, o3_ffb, os_ffa, os_ffb;
  logic [1:0] o1_st, o3_st, os_st;
`ifdef CHK_ONEHOT_EN
  logic [7:0] o1_oh, o3_oh;
  logic [1:0] os_oh;
`endif

  cmp_result_checker #(.WIDTH(4), .LATENCY(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_last(vec_last),
    .vec_a(vec_a), .vec_b(vec_b), .dut_gt(d1[2]), .dut_eq(d1[1]), .dut_lt(d1[0]),
    .busy(o1_busy), .done(o1_done), .pass_cnt(o1_pass), .fail_cnt(o1_fail), .fail_seen(o1_fs),
    .first_fail_a(o1_ffa), .first_fail_b(o1_ffb), .state_dbg(o1_st)
`ifdef CHK_ONEHOT_EN
    , .onehot_err_cnt(o1_oh)
`endif
  );

  cmp_result_checker #(.WIDTH(4), .LATENCY(3), .CNT_W(8)) u3 (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_last(vec_last),
    .vec_a(vec_a), .vec_b(vec_b), .dut_gt(d3[2][2]), .dut_eq(d3[2][1]), .dut_lt(d3[2][0]),
    .busy(o3_busy), .done(o3_done), .pass_cnt(o3_pass), .fail_cnt(o3_fail), .fail_seen(o3_fs),
    .first_fail_a(o3_ffa), .first_fail_b(o3_ffb), .state_dbg(o3_st)
`ifdef CHK_ONEHOT_EN
    , .onehot_err_cnt(o3_oh)
`endif
  );

  cmp_result_checker #(.WIDTH(4), .LATENCY(1), .CNT_W(2)) us (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_last(vec_last),
    .vec_a(vec_a), .vec_b(vec_b), .dut_gt(d1[2]), .dut_eq(d1[1]), .dut_lt(d1[0]),
    .busy(os_busy), .done(os_done), .pass_cnt(os_pass), .fail_cnt(os_fail), .fail_seen(os_fs),
    .first_fail_a(os_ffa), .first_fail_b(os_ffb), .state_dbg(os_st)
`ifdef CHK_ONEHOT_EN
    , .onehot_err_cnt(os_oh)
`endif
  );

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard (latency-1 instance) ----------------
  logic [15:0] exp_q[$];   // {pass_cnt, fail_cnt} expected after each comparison
  logic a1, c1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a1 <= 1'b0;
      c1 <= 1'b0;
    end else begin
      a1 <= sb_acc && vec_valid;
      c1 <= a1;
    end
  end
  always @(posedge rst) exp_q.delete();

  always @(negedge clk) begin
    if (c1 && !rst) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL sb_underflow: got count update with empty queue want none");
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("sb_cnt", {o1_pass, o1_fail}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_vec(input logic [3:0] a, input logic [3:0] b, input logic [2:0] m,
                           input logic last, input logic acc, input int ep, input int ef);
    vec_valid = 1'b1;
    vec_a     = a;
    vec_b     = b;
    vec_last  = last;
    flt       = m;
    sb_acc    = acc;
    if (acc) exp_q.push_back({ep[7:0], ef[7:0]});
    @(negedge clk);
    vec_valid = 1'b0;
    vec_last  = 1'b0;
    flt       = 3'b000;
    sb_acc    = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int k;
    k = 0;
    while (!(o1_done && o3_done && os_done) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    if (!(o1_done && o3_done && os_done)) begin
      n_total++;
      n_bad++;
      $display("FAIL wait_done: got timeout after %0d cycles want done", max_cyc);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] mask;
    logic       last;
    int         gap;
    int         ep;
    int         ef;
  } rec_t;

  rec_t tbl[21];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       new_run;
    logic       ff_set;
    logic [3:0] ffa, ffb;
    int         sat;

    // run A: all pass; run B: eq dropped on first; run C: multi-hot and all-zero faults
    tbl[0]  = '{4'hD, 4'hD, 3'b000, 1'b0, 0, 1, 0};
    tbl[1]  = '{4'h1, 4'hF, 3'b000, 1'b0, 0, 2, 0};
    tbl[2]  = '{4'h2, 4'hE, 3'b000, 1'b0, 0, 3, 0};
    tbl[3]  = '{4'hD, 4'h3, 3'b000, 1'b1, 0, 4, 0};
    tbl[4]  = '{4'hD, 4'hD, 3'b010, 1'b0, 0, 0, 1};
    tbl[5]  = '{4'h1, 4'hF, 3'b000, 1'b0, 0, 1, 1};
    tbl[6]  = '{4'h2, 4'hE, 3'b000, 1'b0, 0, 2, 1};
    tbl[7]  = '{4'hD, 4'h3, 3'b000, 1'b1, 0, 3, 1};
    tbl[8]  = '{4'hD, 4'hD, 3'b000, 1'b0, 0, 1, 0};
    tbl[9]  = '{4'h1, 4'hF, 3'b100, 1'b0, 0, 1, 1};
    tbl[10] = '{4'h2, 4'hE, 3'b000, 1'b0, 0, 2, 1};
    tbl[11] = '{4'hD, 4'h3, 3'b100, 1'b1, 0, 2, 2};
    // run D: six passes with gaps (saturates the 2-bit instance)
    tbl[12] = '{4'h0, 4'h0, 3'b000, 1'b0, 0, 1, 0};
    tbl[13] = '{4'hF, 4'h0, 3'b000, 1'b0, 1, 2, 0};
    tbl[14] = '{4'h0, 4'hF, 3'b000, 1'b0, 0, 3, 0};
    tbl[15] = '{4'h7, 4'h8, 3'b000, 1'b0, 0, 4, 0};
    tbl[16] = '{4'h8, 4'h7, 3'b000, 1'b0, 2, 5, 0};
    tbl[17] = '{4'hA, 4'hA, 3'b000, 1'b1, 0, 6, 0};
    // run E: valid pattern 1,0,1,1
    tbl[18] = '{4'h3, 4'h3, 3'b000, 1'b0, 0, 1, 0};
    tbl[19] = '{4'h9, 4'h2, 3'b000, 1'b0, 1, 2, 0};
    tbl[20] = '{4'h4, 4'hC, 3'b000, 1'b1, 0, 3, 0};

    rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_last = 1'b0;
    vec_a = '0; vec_b = '0; flt = '0; sb_acc = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_busy", o1_busy, 0);
    chk("rst_done", o1_done, 0);
    chk("rst_pass", o1_pass, 0);
    chk("rst_fail", o1_fail, 0);
    chk("rst_fs", o1_fs, 0);
    chk("rst_ff", {o1_ffa, o1_ffb}, 0);
    chk("rst_state", o1_st, 0);
`ifdef CHK_ONEHOT_EN
    chk("rst_oh", o1_oh, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // ---- table-driven runs ----
    new_run = 1'b1; ff_set = 1'b0; ffa = '0; ffb = '0;
    for (int i = 0; i < 21; i++) begin
      if (new_run) begin
        pulse_start();
        new_run = 1'b0; ff_set = 1'b0; ffa = '0; ffb = '0;
        chk("run_busy", o1_busy, 1);
      end
      idle(tbl[i].gap);
      if (tbl[i].mask != 3'b000 && !ff_set) begin
        ff_set = 1'b1; ffa = tbl[i].a; ffb = tbl[i].b;
      end
      drive_vec(tbl[i].a, tbl[i].b, tbl[i].mask, tbl[i].last, 1'b1, tbl[i].ep, tbl[i].ef);
      if (tbl[i].last) begin
        wait_done(40);
        sat = (tbl[i].ep > 3) ? 3 : tbl[i].ep;
        chk("end_done", o1_done, 1);
        chk("end_busy", o1_busy, 0);
        chk("end_pass", o1_pass, tbl[i].ep);
        chk("end_fail", o1_fail, tbl[i].ef);
        chk("end_fs", o1_fs, tbl[i].ef != 0);
        chk("end_ffa", o1_ffa, ffa);
        chk("end_ffb", o1_ffb, ffb);
        chk("end_l3_pass", o3_pass, tbl[i].ep);
        chk("end_l3_fail", o3_fail, tbl[i].ef);
        chk("end_l3_ff", {o3_ffa, o3_ffb}, {ffa, ffb});
        chk("end_sat_pass", os_pass, sat);
        chk("end_sat_fail", os_fail, tbl[i].ef);
        new_run = 1'b1;
      end
    end
    idle(3);
    chk("sat_hold", os_pass, 3);

    // ---- DONE timing for latency 1 and latency 3 ----
    pulse_start();
    drive_vec(4'h5, 4'h5, 3'b000, 1'b1, 1'b1, 1, 0);
    chk("t_l1_done_n", o1_done, 0);
    chk("t_l3_done_n", o3_done, 0);
    @(negedge clk);
    chk("t_l1_done_n1", o1_done, 1);
    chk("t_l1_pass_n1", o1_pass, 1);
    chk("t_l3_done_n1", o3_done, 0);
    @(negedge clk);
    chk("t_l3_done_n2", o3_done, 0);
    chk("t_l3_pass_n2", o3_pass, 0);
    @(negedge clk);
    chk("t_l3_done_n3", o3_done, 1);
    chk("t_l3_pass_n3", o3_pass, 1);

    // ---- start ignored in RUN, vec_valid ignored in DRAIN and DONE ----
    pulse_start();
    drive_vec(4'h1, 4'h2, 3'b000, 1'b0, 1'b1, 1, 0);
    pulse_start();
    drive_vec(4'h3, 4'h3, 3'b000, 1'b1, 1'b1, 2, 0);
    drive_vec(4'h9, 4'h9, 3'b000, 1'b0, 1'b0, 0, 0);
    wait_done(20);
    drive_vec(4'h8, 4'h1, 3'b000, 1'b0, 1'b0, 0, 0);
    idle(3);
    chk("ign_pass", o1_pass, 2);
    chk("ign_fail", o1_fail, 0);
    chk("ign_done", o1_done, 1);
    chk("ign_l3_pass", o3_pass, 2);
    chk("ign_sat_pass", os_pass, 2);

    // ---- reset while the latency-3 instance drains two slots ----
    pulse_start();
    drive_vec(4'h6, 4'h2, 3'b010, 1'b0, 1'b1, 0, 1);
    drive_vec(4'h2, 4'h6, 3'b000, 1'b0, 1'b1, 1, 1);
    drive_vec(4'h7, 4'h7, 3'b000, 1'b1, 1'b1, 2, 1);
    @(negedge clk);
    chk("mr_pre_state", o3_st, 2);
    chk("mr_pre_fs", o3_fs, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_l3_state", o3_st, 0);
    chk("mr_l3_busy", o3_busy, 0);
    chk("mr_l3_cnt", {o3_pass, o3_fail}, 0);
    chk("mr_l3_fs", o3_fs, 0);
    chk("mr_l1_cnt", {o1_pass, o1_fail}, 0);
    chk("mr_l1_fs", o1_fs, 0);
    chk("mr_l1_ff", {o1_ffa, o1_ffb}, 0);
    chk("mr_l1_done", o1_done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    drive_vec(4'hE, 4'h1, 3'b000, 1'b1, 1'b1, 1, 0);
    wait_done(20);
    chk("mr_clean_l3", {o3_pass, o3_fail}, 16'h0100);
    chk("mr_clean_l3_fs", o3_fs, 0);
    chk("mr_clean_l1", {o1_pass, o1_fail}, 16'h0100);

`ifdef CHK_ONEHOT_EN
    // ---- gt and eq both high is a one-hot error and a fail ----
    pulse_start();
    drive_vec(4'h5, 4'h3, 3'b010, 1'b1, 1'b1, 0, 1);
    wait_done(20);
    chk("oh_cnt", o1_oh, 1);
    chk("oh_fail", o1_fail, 1);
    chk("oh_l3_cnt", o3_oh, 1);
`endif

    idle(2);
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
